// File: rtl/sdram_port_arbiter.sv
// Three-port SDRAM request arbiter: one outstanding transaction, port 0 priority with
// anti-starvation for ports 1/2, which share a round-robin.
module sdram_port_arbiter #(
  parameter int ADDR_W       = 24,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            req_valid,
  input  logic [2:0]            req_write,
  input  logic [3*ADDR_W-1:0]   req_addr,
  input  logic [3*DATA_W-1:0]   req_wdata,
  input  logic [3*DATA_W/8-1:0] req_wstrb,
  output logic [2:0]            req_ready,
  output logic [2:0]            resp_valid,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  mem_valid,
  output logic                  mem_write,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_wstrb,
  input  logic                  mem_ready,
  input  logic                  mem_resp_valid,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic [1:0]            grant_id
);
  localparam int STRB_W  = DATA_W / 8;
  localparam int CNT_RAW = $clog2(STARVE_LIMIT + 1);
  localparam int CNT_W   = (CNT_RAW < 2) ? 2 : CNT_RAW;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] NONE  = 2'd3;

  logic [1:0]        state;
  logic [1:0]        owner;
  logic [1:0]        rr_last;
  logic [CNT_W-1:0]  starve_cnt;
  logic [1:0]        rr_pick;
  logic [1:0]        winner;
  logic              other_valid;
  logic              starved;
  logic              accept;
  logic              sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [STRB_W-1:0] sel_wstrb;

  always_comb begin
    other_valid = req_valid[1] | req_valid[2];
    starved     = (starve_cnt == CNT_MAX);

    if (req_valid[1] && req_valid[2]) rr_pick = (rr_last == 2'd2) ? 2'd1 : 2'd2;
    else if (req_valid[1])            rr_pick = 2'd1;
    else                              rr_pick = 2'd2;

    // Port 0 yields only once it has starved the others for STARVE_LIMIT grants
    if (req_valid[0] && !(other_valid && starved)) winner = 2'd0;
    else if (other_valid)                          winner = rr_pick;
    else                                           winner = NONE;

    // No accept during the response cycle so the next grant comes one cycle later
    accept    = (state == IDLE) && !(|resp_valid) && !reset && (winner != NONE);
    req_ready = {winner == 2'd2, winner == 2'd1, winner == 2'd0} & {3{accept}};

    if (accept)                               grant_id = winner;
    else if (state != IDLE || (|resp_valid))  grant_id = owner;
    else                                      grant_id = NONE;

    sel_write = req_write[0];
    sel_addr  = req_addr[0 +: ADDR_W];
    sel_wdata = req_wdata[0 +: DATA_W];
    sel_wstrb = req_wstrb[0 +: STRB_W];
    case (winner)
      2'd1: begin
        sel_write = req_write[1];
        sel_addr  = req_addr[ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[DATA_W +: DATA_W];
        sel_wstrb = req_wstrb[STRB_W +: STRB_W];
      end
      2'd2: begin
        sel_write = req_write[2];
        sel_addr  = req_addr[2*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[2*DATA_W +: DATA_W];
        sel_wstrb = req_wstrb[2*STRB_W +: STRB_W];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= NONE;
      rr_last    <= 2'd2;
      starve_cnt <= '0;
      resp_valid <= '0;
      resp_rdata <= '0;
      mem_valid  <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wstrb  <= '0;
    end else begin
      resp_valid <= '0;
      case (state)
        IDLE: begin
          if (accept) begin
            owner     <= winner;
            state     <= ISSUE;
            mem_valid <= 1'b1;
            mem_write <= sel_write;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            mem_wstrb <= sel_wstrb;
            if (winner == 2'd0 && other_valid) begin
              if (!starved) starve_cnt <= starve_cnt + CNT_W'(1);
            end else begin
              starve_cnt <= '0;
            end
            if (winner != 2'd0) rr_last <= winner;
          end
        end
        ISSUE: begin
          if (mem_ready) begin
            mem_valid <= 1'b0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (mem_resp_valid) begin
            resp_valid <= {owner == 2'd2, owner == 2'd1, owner == 2'd0};
            resp_rdata <= mem_rdata;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
